systolic_result_collector: RTL

- Sits at the output end of the systolic array frame.
- Captures the column-staggered result stream (column j lags column 0 by j cycles), de-skews it into a MATRIX_SIZE x MATRIX_SIZE buffer, then drains it one aligned row per handshake.
- Drives the frame's output_ready back-pressure input.

---
 rtl/systolic_result_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/systolic_result_collector.sv
// systolic_result_collector
//   Captures the column-staggered result stream leaving a systolic array
//   (column j lags column 0 by j cycles), de-skews it into a square buffer,
//   then drains one aligned row per valid/ready handshake.
//
//   Handshake: row_out/row_last are meaningful while row_valid is high; a
//   transfer happens on a rising edge where row_valid && row_ready. While
//   row_ready is low, row_valid, row_out and row_last hold steady.
//
//   Optional feature macro: COLLECT_TRANSPOSE_EN
//     defined   : each drained word is a column (row_out[k] = buffer[k][r])
//     undefined : each drained word is a row    (row_out[k] = buffer[r][k])

module systolic_result_collector #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] result_in,
    input  logic                                  capture_start,
    output logic                                  output_ready,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_out,
    output logic                                  row_valid,
    input  logic                                  row_ready,
    output logic                                  row_last,
    output logic                                  overrun
);

    localparam int CNT_W    = (2*MATRIX_SIZE-1 > 1) ? $clog2(2*MATRIX_SIZE-1) : 1;
    localparam int ROW_W    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int LAST_CNT = 2*MATRIX_SIZE-2;
    localparam int LAST_ROW = MATRIX_SIZE-1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_e;

    state_e                                                   state_q, state_d;
    logic [CNT_W-1:0]                                         cnt_q, cnt_d;
    logic [ROW_W-1:0]                                         r_q, r_d;
    logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]   buffer_q, buffer_d;
    logic                                                     overrun_q, overrun_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: capture counter, drain row index, buffer, error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            r_q       <= '0;
            buffer_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            buffer_q  <= buffer_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic; a capture_start outside IDLE never changes state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (capture_start) begin
                    state_d = (MATRIX_SIZE == 1) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (int'(cnt_q) == LAST_CNT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (row_ready && (int'(r_q) == LAST_ROW)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath update: anti-diagonal store during capture, row walk during drain
    always_comb begin
        cnt_d     = cnt_q;
        r_d       = r_q;
        buffer_d  = buffer_q;
        overrun_d = overrun_q;

        // Any frame strobe while busy (including the last drain beat) is an error
        if (capture_start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (capture_start) begin
                    buffer_d[0][0] = result_in[0];
                    if (MATRIX_SIZE > 1) begin
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                // At count c, column j carries row c-j; only in-range rows are kept
                for (int i = 0; i < MATRIX_SIZE; i++) begin
                    for (int j = 0; j < MATRIX_SIZE; j++) begin
                        if (int'(cnt_q) == i + j) begin
                            buffer_d[i][j] = result_in[j];
                        end
                    end
                end
                cnt_d = (int'(cnt_q) == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
            end
            S_DRAIN: begin
                if (row_ready) begin
                    r_d = (int'(r_q) == LAST_ROW) ? '0 : r_q + ROW_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: decoded from registered state and buffer only
    always_comb begin
        output_ready = (state_q == S_IDLE);
        row_valid    = (state_q == S_DRAIN);
        row_last     = (state_q == S_DRAIN) && (int'(r_q) == LAST_ROW);
        row_out      = '0;
        if (state_q == S_DRAIN) begin
            for (int m = 0; m < MATRIX_SIZE; m++) begin
                if (int'(r_q) == m) begin
`ifdef COLLECT_TRANSPOSE_EN
                    for (int k = 0; k < MATRIX_SIZE; k++) begin
                        row_out[k] = buffer_q[k][m];
                    end
`else
                    row_out = buffer_q[m];
`endif
                end
            end
        end
    end

    assign overrun = overrun_q;

endmodule
